// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: a PC register drives the combinational ROM and a
// two-entry queue of {pc, instr} pairs feeds decode over valid/ready.
// Branch/jump redirects flush the queue and restart fetch at the target.
// Optional feature macro: IFETCH_PERF_EN adds perf_fetched/perf_flushed counters.
module instr_fetch_unit #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned RESET_PC      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_data,
  output logic                     id_valid,
  output logic [DATA_WIDTH-1:0]    id_instr,
  output logic [ADDRESS_WIDTH-1:0] id_pc,
  input  logic                     id_ready,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_flushed
`endif
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  logic [AW-1:0] pc;
  logic [AW-1:0] q_pc    [2];
  logic [DW-1:0] q_instr [2];
  logic          head;
  logic          tail;
  logic [1:0]    count;
  logic          pop;
  logic          push;

  // ROM address is the PC register itself, so it is frozen during a stall
  assign imem_addr = pc;

  // Handshake and queue-write decisions; a redirect suppresses the push
  always_comb begin
    pop  = id_valid & id_ready;
    push = ~redirect_valid & ((count != 2'd2) | pop);
  end

  // Head view, forced to zero when the queue is empty
  always_comb begin
    id_valid = (count != 2'd0);
    id_pc    = '0;
    id_instr = '0;
    if (count != 2'd0) begin
      id_pc    = q_pc[head];
      id_instr = q_instr[head];
    end
  end

  // PC sequencing and queue bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= AW'(RESET_PC);
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else if (redirect_valid) begin
      pc    <= {redirect_pc[AW-1:2], 2'b00};
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      if (push) begin
        q_pc[tail]    <= pc;
        q_instr[tail] <= imem_data;
        tail          <= ~tail;
        pc            <= pc + AW'(4);
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  // Fetch and flush event counters, free-running with natural wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (redirect_valid) begin
        perf_flushed <= perf_flushed + 32'(count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a behavioural ROM
// (word i = 0x100 + i) and a queue of expected {pc, instr} head entries.
// Define IFETCH_PERF_EN for the bench and the design together to cover the counters.
module tb_instr_fetch_unit;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic          id_valid;
  logic [DW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic          id_ready = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
`ifdef IFETCH_PERF_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_flushed;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] exp_e;

  instr_fetch_unit #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RESET_PC(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .id_valid(id_valid),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .id_ready(id_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Combinational ROM model
  assign imem_data = 32'h0000_0100 + 32'(imem_addr >> 2);

  function automatic logic [AW+DW-1:0] rom_entry(input logic [AW-1:0] a);
    return {a, 32'h0000_0100 + 32'(a >> 2)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
    n_cmp++;
    if (id_pc !== 8'h00) begin n_err++; $display("FAIL reset_pc: got %h expected 00", id_pc); end
    n_cmp++;
    if (id_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h expected 0", id_instr); end
    n_cmp++;
    if (imem_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr: got %h expected 00", imem_addr); end
  endtask

  task automatic test_stream();
    apply_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(rom_entry(8'(4 * i)));
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (id_valid !== 1'b1 || exp_q.size() == 0) begin
        n_err++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, id_valid);
      end else begin
        exp_e = exp_q.pop_front();
        n_cmp++;
        if ({id_pc, id_instr} !== exp_e) begin
          n_err++; $display("FAIL stream_head[%0d]: got %h/%h expected %h/%h", i, id_pc, id_instr, exp_e[39:32], exp_e[31:0]);
        end
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    for (int i = 0; i < 3; i++) exp_q.push_back(rom_entry(8'(4 * i)));
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i >= 1) begin
        n_cmp++;
        if (imem_addr !== 8'h08) begin n_err++; $display("FAIL stall_addr[%0d]: got %h expected 08", i, imem_addr); end
        n_cmp++;
        if (id_valid !== 1'b1 || id_pc !== 8'h00 || id_instr !== 32'h100) begin
          n_err++; $display("FAIL stall_head[%0d]: got %b %h/%h expected 1 00/00000100", i, id_valid, id_pc, id_instr);
        end
      end
    end
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (id_valid && id_ready) begin
        exp_e = exp_q.pop_front();
        n_cmp++;
        if ({id_pc, id_instr} !== exp_e) begin
          n_err++; $display("FAIL stall_drain[%0d]: got %h/%h expected %h/%h", i, id_pc, id_instr, exp_e[39:32], exp_e[31:0]);
        end
      end else begin
        n_cmp++; n_err++; $display("FAIL stall_drain_valid[%0d]: got %b expected 1", i, id_valid);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    tick(); tick();
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 8'h41;
    tick();
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    n_cmp++;
    if (id_valid !== 1'b0 || imem_addr !== 8'h40) begin
      n_err++; $display("FAIL redir_flush: got %b/%h expected 0/40", id_valid, imem_addr);
    end
    tick();
    n_cmp++;
    if (id_valid !== 1'b1 || id_pc !== 8'h40 || id_instr !== 32'h110) begin
      n_err++; $display("FAIL redir_target: got %b %h/%h expected 1 40/00000110", id_valid, id_pc, id_instr);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] a;
    redirect_valid = 1'b1;
    redirect_pc = 8'hF8;
    id_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (id_valid !== 1'b0 || imem_addr !== 8'hF8) begin
      n_err++; $display("FAIL wrap_flush: got %b/%h expected 0/f8", id_valid, imem_addr);
    end
    exp_q.delete();
    a = 8'hF8;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(rom_entry(a));
      a = a + 8'd4;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_e = exp_q.pop_front();
      n_cmp++;
      if (id_valid !== 1'b1 || {id_pc, id_instr} !== exp_e) begin
        n_err++; $display("FAIL wrap_head[%0d]: got %b %h/%h expected 1 %h/%h", i, id_valid, id_pc, id_instr, exp_e[39:32], exp_e[31:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 8'h20;
    tick();
    redirect_pc = 8'h33;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (id_valid !== 1'b0 || imem_addr !== 8'h30) begin
      n_err++; $display("FAIL b2b_flush: got %b/%h expected 0/30", id_valid, imem_addr);
    end
    tick();
    n_cmp++;
    if (id_pc !== 8'h30 || id_instr !== 32'h10C) begin
      n_err++; $display("FAIL b2b_target: got %h/%h expected 30/0000010c", id_pc, id_instr);
    end
  endtask

  task automatic test_mid_reset(input logic with_redirect);
    apply_reset();
    tick(); tick();
    rst = 1'b1;
    id_ready = 1'b1;
    redirect_valid = with_redirect;
    redirect_pc = 8'h80;
    tick();
    rst = 1'b0;
    redirect_valid = 1'b0;
    n_cmp++;
    if (id_valid !== 1'b0 || imem_addr !== 8'h00 || id_pc !== 8'h00 || id_instr !== 32'h0) begin
      n_err++; $display("FAIL midrst_state[%0d]: got %b %h %h/%h expected 0 00 00/0", with_redirect, id_valid, imem_addr, id_pc, id_instr);
    end
    tick();
    n_cmp++;
    if (id_valid !== 1'b1 || id_pc !== 8'h00 || id_instr !== 32'h100) begin
      n_err++; $display("FAIL midrst_first[%0d]: got %b %h/%h expected 1 00/00000100", with_redirect, id_valid, id_pc, id_instr);
    end
  endtask

`ifdef IFETCH_PERF_EN
  task automatic test_perf();
    apply_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    id_ready = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 8'h10;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (perf_fetched !== 32'd5) begin n_err++; $display("FAIL perf_fetched: got %0d expected 5", perf_fetched); end
    n_cmp++;
    if (perf_flushed !== 32'd2) begin n_err++; $display("FAIL perf_flushed: got %0d expected 2", perf_flushed); end
    apply_reset();
    n_cmp++;
    if (perf_fetched !== 32'd0 || perf_flushed !== 32'd0) begin
      n_err++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", perf_fetched, perf_flushed);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_mid_reset(1'b0);
    test_mid_reset(1'b1);
`ifdef IFETCH_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
